// File: rtl/flag_br_unit.sv
// Flag register and branch resolution with a registered PC redirect and flush.
// Define BR_FLAG_BYPASS_EN to evaluate conditions on same-cycle flag writes.
module flag_br_unit #(
  parameter int AW        = 17,
  parameter int FLUSH_CYC = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          zr,
  input  logic          ov,
  input  logic          neg,
  input  logic          upd_zr,
  input  logic          upd_vn,
  input  logic          br_instr,
  input  logic          jmp_instr,
  input  logic [2:0]    cc,
  input  logic [AW-1:0] tgt,
  output logic          pc_sel,
  output logic [AW-1:0] pc_tgt,
  output logic          flush,
  output logic [2:0]    flags
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYC - 1);

  state_t     state;
  logic [1:0] cnt;
  logic       z, v, n;
  logic       fz, fv, fn;
  logic       cond;
  logic       taken;

  assign flags = {z, v, n};

`ifdef BR_FLAG_BYPASS_EN
  assign fz = upd_zr ? zr  : z;
  assign fv = upd_vn ? ov  : v;
  assign fn = upd_vn ? neg : n;
`else
  assign fz = z;
  assign fv = v;
  assign fn = n;
`endif

  always_comb begin
    cond = 1'b0;
    unique case (cc)
      3'b000: cond = ~fz;
      3'b001: cond = fz;
      3'b010: cond = ~fz & ~fn;
      3'b011: cond = fn;
      3'b100: cond = ~fn;
      3'b101: cond = fn | fz;
      3'b110: cond = fv;
      3'b111: cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  assign taken = jmp_instr | (br_instr & cond);

  // In FLUSH the EX slot is a squashed instruction: no flag write, no redirect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      pc_sel <= 1'b0;
      pc_tgt <= '0;
      flush  <= 1'b0;
      z      <= 1'b0;
      v      <= 1'b0;
      n      <= 1'b0;
    end else if (!stall) begin
      pc_sel <= 1'b0;
      unique case (state)
        IDLE: begin
          if (upd_zr) z <= zr;
          if (upd_vn) begin
            v <= ov;
            n <= neg;
          end
          if (taken) begin
            pc_sel <= 1'b1;
            pc_tgt <= tgt;
            flush  <= 1'b1;
            state  <= FLUSH;
            cnt    <= CNT_INIT;
          end
        end
        FLUSH: begin
          if (cnt == 2'd0) begin
            state <= IDLE;
            flush <= 1'b0;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flag_br_unit.sv
// Directed bench for flag_br_unit with a one-cycle-latency scoreboard.
// Expectations follow BR_FLAG_BYPASS_EN when the build defines it.
module tb_flag_br_unit;

  localparam int AW = 17;

  typedef struct {
    logic          sel;
    logic          fl;
    logic [AW-1:0] tg;
    logic [2:0]    fg;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n, stall, zr, ov, neg;
  logic          upd_zr, upd_vn, br_instr, jmp_instr;
  logic [2:0]    cc;
  logic [AW-1:0] tgt;
  logic          pc_sel, flush;
  logic [AW-1:0] pc_tgt;
  logic [2:0]    flags;

  exp_t q[$];
  int   nvec = 0;
  int   nmis = 0;
  int   stp  = 0;

  flag_br_unit #(.AW(AW), .FLUSH_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .zr(zr), .ov(ov), .neg(neg),
    .upd_zr(upd_zr), .upd_vn(upd_vn),
    .br_instr(br_instr), .jmp_instr(jmp_instr),
    .cc(cc), .tgt(tgt),
    .pc_sel(pc_sel), .pc_tgt(pc_tgt),
    .flush(flush), .flags(flags)
  );

  always #5 clk = ~clk;

  // Drive one cycle, push expected post-edge outputs, then pop and compare.
  task automatic step(
    input logic          r, s,
    input logic          iz, iv, in_,
    input logic          uz, uv,
    input logic          b, j,
    input logic [2:0]    c,
    input logic [AW-1:0] t,
    input logic          esel, efl,
    input logic [AW-1:0] etg,
    input logic [2:0]    efg
  );
    exp_t e;
    rst_n = r; stall = s;
    zr = iz; ov = iv; neg = in_;
    upd_zr = uz; upd_vn = uv;
    br_instr = b; jmp_instr = j;
    cc = c; tgt = t;
    q.push_back('{esel, efl, etg, efg});
    @(posedge clk);
    #1;
    stp++;
    e = q.pop_front();
    nvec++;
    assert (pc_sel === e.sel) else begin
      nmis++;
      $error("FAIL step%0d pc_sel got %b exp %b", stp, pc_sel, e.sel);
    end
    nvec++;
    assert (flush === e.fl) else begin
      nmis++;
      $error("FAIL step%0d flush got %b exp %b", stp, flush, e.fl);
    end
    nvec++;
    assert (pc_tgt === e.tg) else begin
      nmis++;
      $error("FAIL step%0d pc_tgt got %h exp %h", stp, pc_tgt, e.tg);
    end
    nvec++;
    assert (flags === e.fg) else begin
      nmis++;
      $error("FAIL step%0d flags got %b exp %b", stp, flags, e.fg);
    end
  endtask

  initial begin
    logic [AW-1:0] t34;
    logic          b34;
`ifdef BR_FLAG_BYPASS_EN
    b34 = 1'b1;
    t34 = 17'h00777;
`else
    b34 = 1'b0;
    t34 = 17'h0ABCD;
`endif
    rst_n = 0; stall = 0; zr = 0; ov = 0; neg = 0;
    upd_zr = 0; upd_vn = 0; br_instr = 0; jmp_instr = 0;
    cc = 0; tgt = 0;
    #2;
    // reset, and reset over stall
    step(0,0, 0,0,0, 0,0, 0,0, 3'b000, 17'h0, 0,0, 17'h0, 3'b000);
    step(0,1, 0,0,0, 0,0, 0,1, 3'b111, 17'h1, 0,0, 17'h0, 3'b000);
    // BEQ with Z=0 never redirects
    for (int i = 0; i < 4; i++)
      step(1,0, 0,0,0, 0,0, 1,0, 3'b001, 17'h00123, 0,0, 17'h0, 3'b000);
    // set Z, then BEQ taken
    step(1,0, 1,0,0, 1,0, 0,0, 3'b000, 17'h0, 0,0, 17'h0, 3'b100);
    step(1,0, 0,0,0, 0,0, 1,0, 3'b001, 17'h0ABCD, 1,1, 17'h0ABCD, 3'b100);
    step(1,0, 0,0,0, 0,0, 0,0, 3'b000, 17'h0, 0,1, 17'h0ABCD, 3'b100);
    step(1,0, 0,0,0, 0,0, 0,0, 3'b000, 17'h0, 0,0, 17'h0ABCD, 3'b100);
    // taken branch, then JMP and flag writes in squashed slots
    step(1,0, 0,0,0, 0,0, 1,0, 3'b001, 17'h00555, 1,1, 17'h00555, 3'b100);
    step(1,0, 0,1,1, 1,1, 0,1, 3'b111, 17'h1F0F0, 0,1, 17'h00555, 3'b100);
    step(1,0, 0,1,1, 1,1, 0,1, 3'b111, 17'h1F0F0, 0,0, 17'h00555, 3'b100);
    // NE with Z=1 not taken; restores pc_tgt context for later steps
    step(1,0, 0,0,0, 0,0, 1,0, 3'b000, 17'h00666, 0,0, 17'h00555, 3'b100);
    step(1,0, 0,0,0, 0,0, 1,0, 3'b001, 17'h0ABCD, 1,1, 17'h0ABCD, 3'b100);
    step(1,0, 0,0,0, 0,0, 0,0, 3'b000, 17'h0, 0,1, 17'h0ABCD, 3'b100);
    step(1,0, 0,0,0, 0,0, 0,0, 3'b000, 17'h0, 0,0, 17'h0ABCD, 3'b100);
    // same-cycle N write and BLT: outcome depends on bypass build
    step(1,0, 0,0,1, 0,1, 1,0, 3'b011, 17'h00777, b34,b34, t34, 3'b101);
    step(1,0, 0,0,0, 0,0, 0,0, 3'b000, 17'h0, 0,b34, t34, 3'b101);
    step(1,0, 0,0,0, 0,0, 0,0, 3'b000, 17'h0, 0,0, t34, 3'b101);
    // GT with Z=1,N=1 not taken
    step(1,0, 0,0,0, 0,0, 1,0, 3'b010, 17'h00999, 0,0, t34, 3'b101);
    // taken BLT held by stall for 3 cycles
    for (int i = 0; i < 3; i++)
      step(1,1, 0,0,0, 0,0, 1,0, 3'b011, 17'h01234, 0,0, t34, 3'b101);
    step(1,0, 0,0,0, 0,0, 1,0, 3'b011, 17'h01234, 1,1, 17'h01234, 3'b101);
    // stall inside the redirect cycle holds pc_sel and flush
    step(1,1, 0,0,0, 0,0, 0,1, 3'b111, 17'h1EEEE, 1,1, 17'h01234, 3'b101);
    step(1,0, 0,0,0, 0,0, 0,0, 3'b000, 17'h0, 0,1, 17'h01234, 3'b101);
    step(1,0, 0,0,0, 0,0, 0,0, 3'b000, 17'h0, 0,0, 17'h01234, 3'b101);
    // JMP, reset in second flush cycle, then JMP to top address
    step(1,0, 0,0,0, 0,0, 0,1, 3'b000, 17'h02222, 1,1, 17'h02222, 3'b101);
    step(1,0, 0,0,0, 0,0, 0,0, 3'b000, 17'h0, 0,1, 17'h02222, 3'b101);
    step(0,0, 0,0,0, 0,0, 0,0, 3'b000, 17'h0, 0,0, 17'h0, 3'b000);
    step(1,0, 0,0,0, 0,0, 0,1, 3'b000, 17'h1FFFF, 1,1, 17'h1FFFF, 3'b000);
    step(1,0, 0,0,0, 0,0, 0,0, 3'b000, 17'h0, 0,1, 17'h1FFFF, 3'b000);
    step(1,0, 0,0,0, 0,0, 0,0, 3'b000, 17'h0, 0,0, 17'h1FFFF, 3'b000);
    // V write alone, then OV branch taken on registered V
    step(1,0, 1,1,0, 0,1, 0,0, 3'b000, 17'h0, 0,0, 17'h1FFFF, 3'b010);
    step(1,0, 0,0,0, 0,0, 1,0, 3'b110, 17'h00042, 1,1, 17'h00042, 3'b010);
    step(1,0, 0,0,0, 0,0, 0,0, 3'b000, 17'h0, 0,1, 17'h00042, 3'b010);
    step(1,0, 0,0,0, 0,0, 0,0, 3'b000, 17'h0, 0,0, 17'h00042, 3'b010);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
